mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage and MEM/WB pipeline register for the pipelined MIPS datapath. It consumes the EX/MEM latch outputs and issues at most one data-cache read or write per instruction. While the cache has not answered, it stalls the front of the pipe. It then selects the write-back value and latches it, with the register-write controls, into the MEM/WB register. It also owns the sticky processor halt.

## Interface
Parameters:
- WAITCNT_W, 32, width of the saturating dcache wait-cycle counter.

Ports:
- CLK  in  1  pipeline clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- aluOutport_in  in  32  EX/MEM ALU result; data address for loads and stores.
- rdat2_in  in  32  EX/MEM store data.
- pcplus4_in  in  32  EX/MEM PC+4, the link value for JAL.
- writeReg_in  in  5  destination register.
- regWEN_in, MemToReg_in, JType_in, dMemREN_in, dMemWEN_in, Halt_in  in  1 each  EX/MEM controls.
- dhit  in  1  dcache done for the current request.
- dmemload  in  32  dcache read data, valid when dhit is high.
- dmemREN, dmemWEN  out  1 each  dcache request strobes.
- dmemaddr, dmemstore  out  32 each  request address and store data.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM (writeEN low).
- memfwd_data  out  32  forwarding value for the instruction currently in MEM.
- wb_regWEN  out  1  MEM/WB register write enable.
- wb_writeReg  out  5  MEM/WB destination register.
- wb_wdat  out  32  MEM/WB write-back data.
- halt  out  1  sticky processor halt.
- wait_cnt  out  WAITCNT_W  count of stalled cycles.
- wb_instr, wb_pc  out  32 each  trace fields; see Configuration.
- instr_in, next_pc_in  in  32 each  trace inputs.

## Operation
- Memory op present: mop = (dMemREN_in | dMemWEN_in) & state != HALTED.
  - A load takes priority if both strobes are set.
- FSM states:
  - IDLE
    - Drive dmemREN = dMemREN_in & mop and dmemWEN = dMemWEN_in & ~dMemREN_in & mop, combinationally.
    - If mop and dhit: the access completes this cycle.
    - If mop and no dhit: go to WAIT.
  - WAIT
    - Hold the request strobes; address and data come from the still-frozen EX/MEM latch.
    - On dhit: return to IDLE.
  - HALTED
    - Entered on the edge that latches Halt_in into MEM/WB.
    - Strobes are forced to 0 and mem_stall to 0; leave only by reset.
- Stall and addressing:
  - mem_stall = mop & ~dhit.
  - dmemaddr = aluOutport_in and dmemstore = rdat2_in, always.
- Write-back select, priority order: MemToReg_in → dmemload; JType_in → pcplus4_in; otherwise aluOutport_in.
  - memfwd_data uses the same select, except it gives aluOutport_in whenever MemToReg_in is set, because a load value is not forwardable from MEM.
- MEM/WB update, on each edge where mem_stall is 0:
  - wb_regWEN ← regWEN_in & (writeReg_in != 0).
  - wb_writeReg and wb_wdat ← write-back select.
  - halt ← halt | Halt_in.
- When mem_stall is 1, MEM/WB takes a bubble: wb_regWEN ← 0, all other fields hold.
- While halted, MEM/WB takes bubbles every cycle.
- A store never writes a register, even if regWEN_in is set erroneously: wb_regWEN is 0 when dMemWEN_in is set without dMemREN_in.
- wait_cnt increments on each cycle where mem_stall is 1 and saturates at all-ones.

## Timing
- Reset: state=IDLE, halt=0, wait_cnt=0, all wb_* outputs 0.
  - dmemREN, dmemWEN and mem_stall are 0 as long as nRST is low.
- Reset mid-WAIT: the FSM returns to IDLE asynchronously and the request drops in the same cycle.
- dhit in the first cycle: zero added latency; result visible on wb_* one edge later.
- N miss cycles: mem_stall is high for exactly N cycles, and wait_cnt grows by N.
- dhit is ignored when no request is driven.
- Halt_in together with a memory op: the access completes first, then halt rises on that instruction's MEM/WB edge.
- halt rises one edge after Halt_in is sampled without a stall.

## Configuration
- MEMWB_DEBUG_EN defined:
  - wb_instr ← instr_in and wb_pc ← next_pc_in, on the same enable as MEM/WB.
  - Both reset to 0 and do not change on bubbles.
- MEMWB_DEBUG_EN undefined: wb_instr and wb_pc are tied to 0 and no flops are inferred.

## Test plan
- LW with aluOutport_in=0x100 and dhit on the first cycle:
  - dmemREN=1 and dmemaddr=0x100 that cycle, mem_stall=0.
  - Next edge: wb_wdat equals dmemload, wb_regWEN=1.
- SW with dhit after 3 cycles:
  - mem_stall high for exactly 3 cycles and dmemWEN held throughout.
  - wb_regWEN=0 afterward; wait_cnt=3.
- JAL with writeReg_in=31 and pcplus4_in=0x44: wb_wdat=0x44, wb_writeReg=31.
- ADD targeting $0: wb_regWEN=0.
- HALT followed by an LW:
  - halt=1 one edge after HALT; dmemREN stays 0.
  - halt stays 1 until nRST is asserted.
- nRST pulsed low while in WAIT: dmemREN drops immediately; all outputs read 0; state returns to IDLE.

Source files
------------

// File: rtl/mem_stage.sv
// MIPS memory-access stage with MEM/WB register and sticky halt; one dcache access per instruction, stalls the front of the pipe until dhit.
// Optional trace capture into MEM/WB is enabled by defining MEMWB_DEBUG_EN.
module mem_stage #(
    parameter int WAITCNT_W = 32
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [31:0]          aluOutport_in,
    input  logic [31:0]          rdat2_in,
    input  logic [31:0]          pcplus4_in,
    input  logic [4:0]           writeReg_in,
    input  logic                 regWEN_in,
    input  logic                 MemToReg_in,
    input  logic                 JType_in,
    input  logic                 dMemREN_in,
    input  logic                 dMemWEN_in,
    input  logic                 Halt_in,
    input  logic                 dhit,
    input  logic [31:0]          dmemload,
    output logic                 dmemREN,
    output logic                 dmemWEN,
    output logic [31:0]          dmemaddr,
    output logic [31:0]          dmemstore,
    output logic                 mem_stall,
    output logic [31:0]          memfwd_data,
    output logic                 wb_regWEN,
    output logic [4:0]           wb_writeReg,
    output logic [31:0]          wb_wdat,
    output logic                 halt,
    output logic [WAITCNT_W-1:0] wait_cnt,
    output logic [31:0]          wb_instr,
    output logic [31:0]          wb_pc,
    input  logic [31:0]          instr_in,
    input  logic [31:0]          next_pc_in
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_wb_regWEN;
    logic [4:0]            r_wb_writeReg;
    logic [31:0]           r_wb_wdat;
    logic                  r_halt;
    logic [WAITCNT_W-1:0]  r_wait_cnt;

    logic                  w_mop;
    logic                  w_stall;
    logic                  w_mwb_en;
    logic                  w_is_store;
    logic                  w_regwen;
    logic [31:0]           w_wsel;

    // IDLE and WAIT drive the same strobes: EX/MEM is frozen during WAIT, so the request is simply held.
    assign w_mop      = (dMemREN_in | dMemWEN_in) & (r_state != S_HALTED);
    assign w_stall    = w_mop & ~dhit;
    assign w_mwb_en   = ~w_stall & (r_state != S_HALTED);
    assign w_is_store = dMemWEN_in & ~dMemREN_in;
    assign w_regwen   = regWEN_in & (writeReg_in != 5'd0) & ~w_is_store;

    assign dmemREN   = nRST & dMemREN_in & w_mop;
    assign dmemWEN   = nRST & dMemWEN_in & ~dMemREN_in & w_mop;
    assign mem_stall = nRST & w_stall;
    assign dmemaddr  = aluOutport_in;
    assign dmemstore = rdat2_in;

    always_comb begin
        w_wsel = aluOutport_in;
        if (MemToReg_in)
            w_wsel = dmemload;
        else if (JType_in)
            w_wsel = pcplus4_in;
    end

    // A load result is not available for forwarding until write-back.
    assign memfwd_data = (!MemToReg_in && JType_in) ? pcplus4_in : aluOutport_in;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state       <= S_IDLE;
            r_wb_regWEN   <= 1'b0;
            r_wb_writeReg <= 5'd0;
            r_wb_wdat     <= 32'd0;
            r_halt        <= 1'b0;
            r_wait_cnt    <= '0;
        end else begin
            if (w_stall && (r_wait_cnt != {WAITCNT_W{1'b1}}))
                r_wait_cnt <= r_wait_cnt + WAITCNT_W'(1);
            case (r_state)
                S_IDLE, S_WAIT: begin
                    if (w_stall) begin
                        r_state     <= S_WAIT;
                        r_wb_regWEN <= 1'b0;
                    end else begin
                        r_wb_regWEN   <= w_regwen;
                        r_wb_writeReg <= writeReg_in;
                        r_wb_wdat     <= w_wsel;
                        r_halt        <= r_halt | Halt_in;
                        r_state       <= Halt_in ? S_HALTED : S_IDLE;
                    end
                end
                S_HALTED: begin
                    r_wb_regWEN <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_wb_regWEN <= 1'b0;
                end
            endcase
        end
    end

    assign wb_regWEN   = r_wb_regWEN;
    assign wb_writeReg = r_wb_writeReg;
    assign wb_wdat     = r_wb_wdat;
    assign halt        = r_halt;
    assign wait_cnt    = r_wait_cnt;

`ifdef MEMWB_DEBUG_EN
    logic [31:0] r_wb_instr;
    logic [31:0] r_wb_pc;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_wb_instr <= 32'd0;
            r_wb_pc    <= 32'd0;
        end else if (w_mwb_en) begin
            r_wb_instr <= instr_in;
            r_wb_pc    <= next_pc_in;
        end
    end

    assign wb_instr = r_wb_instr;
    assign wb_pc    = r_wb_pc;
`else
    logic w_unused_trace;
    assign w_unused_trace = ^{instr_in, next_pc_in, w_mwb_en};
    assign wb_instr = 32'd0;
    assign wb_pc    = 32'd0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: vector table, hand-written multi-cycle sequences, then random traffic against a reference model.
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] aluOutport_in, rdat2_in, pcplus4_in, dmemload, instr_in, next_pc_in;
    logic [4:0]  writeReg_in;
    logic        regWEN_in, MemToReg_in, JType_in, dMemREN_in, dMemWEN_in, Halt_in, dhit;
    logic        dmemREN, dmemWEN, mem_stall, wb_regWEN, halt;
    logic [31:0] dmemaddr, dmemstore, memfwd_data, wb_wdat, wb_instr, wb_pc;
    logic [4:0]  wb_writeReg;
    logic [31:0] wait_cnt;

    int n_pass  = 0;
    int n_total = 0;

    mem_stage dut (
        .CLK(CLK), .nRST(nRST),
        .aluOutport_in(aluOutport_in), .rdat2_in(rdat2_in), .pcplus4_in(pcplus4_in),
        .writeReg_in(writeReg_in), .regWEN_in(regWEN_in), .MemToReg_in(MemToReg_in),
        .JType_in(JType_in), .dMemREN_in(dMemREN_in), .dMemWEN_in(dMemWEN_in), .Halt_in(Halt_in),
        .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_stall(mem_stall), .memfwd_data(memfwd_data),
        .wb_regWEN(wb_regWEN), .wb_writeReg(wb_writeReg), .wb_wdat(wb_wdat),
        .halt(halt), .wait_cnt(wait_cnt),
        .wb_instr(wb_instr), .wb_pc(wb_pc),
        .instr_in(instr_in), .next_pc_in(next_pc_in)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic clear_inputs();
        aluOutport_in = 0; rdat2_in = 0; pcplus4_in = 0; dmemload = 0;
        instr_in = 0; next_pc_in = 0; writeReg_in = 0;
        regWEN_in = 0; MemToReg_in = 0; JType_in = 0;
        dMemREN_in = 0; dMemWEN_in = 0; Halt_in = 0; dhit = 0;
    endtask

    // Ends at posedge+1 with outputs of the reset state settled.
    task automatic hard_reset();
        clear_inputs();
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic        ren, wen, rwen, m2r, jt, hit;
        logic [4:0]  wr;
        logic [31:0] alu, rd2, pc4, load;
        logic        e_ren, e_wen, e_stall, e_rwen;
        logic [31:0] e_fwd, e_wdat;
    } vec_t;

    vec_t vecs[7];

    // ---------------- reference model ----------------
    logic        m_halt, m_wen;
    logic [4:0]  m_wreg;
    logic [31:0] m_wdat, m_wait;

    task automatic model_reset();
        m_halt = 0; m_wen = 0; m_wreg = 0; m_wdat = 0; m_wait = 0;
    endtask

    // Inputs already driven; checks combinational outputs, clocks once, checks MEM/WB.
    task automatic run_cycle();
        logic mop, e_stall;
        logic [31:0] e_fwd;
        mop     = (dMemREN_in || dMemWEN_in) && !m_halt;
        e_stall = mop && !dhit;
        e_fwd   = (JType_in && !MemToReg_in) ? pcplus4_in : aluOutport_in;
        #1;
        chk("rnd_dmemREN", {31'd0, dmemREN}, {31'd0, dMemREN_in && mop});
        chk("rnd_dmemWEN", {31'd0, dmemWEN}, {31'd0, dMemWEN_in && !dMemREN_in && mop});
        chk("rnd_stall", {31'd0, mem_stall}, {31'd0, e_stall});
        chk("rnd_fwd", memfwd_data, e_fwd);
        chk("rnd_addr", dmemaddr, aluOutport_in);
        if (!m_halt && !e_stall) begin
            m_wen  = regWEN_in && (writeReg_in != 0) && !(dMemWEN_in && !dMemREN_in);
            m_wreg = writeReg_in;
            m_wdat = MemToReg_in ? dmemload : (JType_in ? pcplus4_in : aluOutport_in);
            if (Halt_in) m_halt = 1;
        end else begin
            m_wen = 0;
        end
        if (e_stall && m_wait != 32'hFFFF_FFFF) m_wait++;
        tick();
        chk("rnd_wb_regWEN", {31'd0, wb_regWEN}, {31'd0, m_wen});
        chk("rnd_wb_writeReg", {27'd0, wb_writeReg}, {27'd0, m_wreg});
        chk("rnd_wb_wdat", wb_wdat, m_wdat);
        chk("rnd_halt", {31'd0, halt}, {31'd0, m_halt});
        chk("rnd_wait_cnt", wait_cnt, m_wait);
    endtask

    initial begin
        //               name     ren wen rwen m2r jt hit wr  alu           rd2      pc4      load          eREN eWEN eST eRW eFWD          eWDAT
        vecs[0] = '{"lw",      1, 0, 1, 1, 0, 1, 5'd5,  32'h100, 32'h0,    32'h0,  32'hDEADBEEF, 1, 0, 0, 1, 32'h100, 32'hDEADBEEF};
        vecs[1] = '{"add_r0",  0, 0, 1, 0, 0, 0, 5'd0,  32'h55,  32'h0,    32'h0,  32'h0,        0, 0, 0, 0, 32'h55,  32'h55};
        vecs[2] = '{"jal",     0, 0, 1, 0, 1, 0, 5'd31, 32'h999, 32'h0,    32'h44, 32'h0,        0, 0, 0, 1, 32'h44,  32'h44};
        vecs[3] = '{"sw_rwen", 0, 1, 1, 0, 0, 1, 5'd7,  32'h200, 32'h1234, 32'h0,  32'h0,        0, 1, 0, 0, 32'h200, 32'h200};
        vecs[4] = '{"ren_wen", 1, 1, 1, 1, 0, 1, 5'd3,  32'h300, 32'h9,    32'h0,  32'hCAFE,     1, 0, 0, 1, 32'h300, 32'hCAFE};
        vecs[5] = '{"hit_idle",0, 0, 1, 0, 0, 1, 5'd9,  32'h77,  32'h0,    32'h0,  32'h5A5A,     0, 0, 0, 1, 32'h77,  32'h77};
        vecs[6] = '{"m2r_jt",  1, 0, 1, 1, 1, 1, 5'd12, 32'h400, 32'h0,    32'h88, 32'hBEEF,     1, 0, 0, 1, 32'h400, 32'hBEEF};

        // Reset state, checked while nRST is still low with a load request on the inputs.
        clear_inputs();
        nRST = 1'b0;
        dMemREN_in = 1; MemToReg_in = 1; regWEN_in = 1; writeReg_in = 5'd2;
        #12;
        chk("rst_dmemREN", {31'd0, dmemREN}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_wb_regWEN", {31'd0, wb_regWEN}, 32'd0);
        chk("rst_wb_wdat", wb_wdat, 32'd0);
        chk("rst_wb_writeReg", {27'd0, wb_writeReg}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_wait_cnt", wait_cnt, 32'd0);
        chk("rst_wb_instr", wb_instr, 32'd0);
        chk("rst_wb_pc", wb_pc, 32'd0);
        hard_reset();

        // Single-instruction vectors, all completing without a stall.
        for (int i = 0; i < 7; i++) begin
            dMemREN_in = vecs[i].ren; dMemWEN_in = vecs[i].wen; regWEN_in = vecs[i].rwen;
            MemToReg_in = vecs[i].m2r; JType_in = vecs[i].jt; dhit = vecs[i].hit;
            writeReg_in = vecs[i].wr; aluOutport_in = vecs[i].alu; rdat2_in = vecs[i].rd2;
            pcplus4_in = vecs[i].pc4; dmemload = vecs[i].load; Halt_in = 0;
            #1;
            chk({vecs[i].name, "_dmemREN"}, {31'd0, dmemREN}, {31'd0, vecs[i].e_ren});
            chk({vecs[i].name, "_dmemWEN"}, {31'd0, dmemWEN}, {31'd0, vecs[i].e_wen});
            chk({vecs[i].name, "_stall"}, {31'd0, mem_stall}, {31'd0, vecs[i].e_stall});
            chk({vecs[i].name, "_fwd"}, memfwd_data, vecs[i].e_fwd);
            chk({vecs[i].name, "_addr"}, dmemaddr, vecs[i].alu);
            chk({vecs[i].name, "_store"}, dmemstore, vecs[i].rd2);
            tick();
            chk({vecs[i].name, "_wb_regWEN"}, {31'd0, wb_regWEN}, {31'd0, vecs[i].e_rwen});
            chk({vecs[i].name, "_wb_wdat"}, wb_wdat, vecs[i].e_wdat);
            chk({vecs[i].name, "_wb_writeReg"}, {27'd0, wb_writeReg}, {27'd0, vecs[i].wr});
        end

        // SW with three miss cycles.
        hard_reset();
        dMemWEN_in = 1; regWEN_in = 1; writeReg_in = 5'd6; aluOutport_in = 32'h500; rdat2_in = 32'h77; dhit = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("sw_stall", {31'd0, mem_stall}, 32'd1);
            chk("sw_dmemWEN", {31'd0, dmemWEN}, 32'd1);
            tick();
            chk("sw_bubble", {31'd0, wb_regWEN}, 32'd0);
        end
        dhit = 1;
        #1;
        chk("sw_done_stall", {31'd0, mem_stall}, 32'd0);
        chk("sw_done_wen", {31'd0, dmemWEN}, 32'd1);
        tick();
        chk("sw_wb_regWEN", {31'd0, wb_regWEN}, 32'd0);
        chk("sw_wait_cnt", wait_cnt, 32'd3);

        // HALT followed by LW; halt is sticky until reset.
        hard_reset();
        Halt_in = 1;
        tick();
        chk("halt_rise", {31'd0, halt}, 32'd1);
        clear_inputs();
        dMemREN_in = 1; MemToReg_in = 1; regWEN_in = 1; writeReg_in = 5'd8; dhit = 0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("halted_dmemREN", {31'd0, dmemREN}, 32'd0);
            chk("halted_stall", {31'd0, mem_stall}, 32'd0);
            tick();
            chk("halted_halt", {31'd0, halt}, 32'd1);
            chk("halted_wb_regWEN", {31'd0, wb_regWEN}, 32'd0);
        end
        hard_reset();
        chk("halt_cleared", {31'd0, halt}, 32'd0);

        // HALT riding on a load: the access must finish before halt rises.
        dMemREN_in = 1; MemToReg_in = 1; regWEN_in = 1; writeReg_in = 5'd4; Halt_in = 1;
        dmemload = 32'h1111; dhit = 0;
        tick(); tick();
        chk("halt_ld_wait", {31'd0, halt}, 32'd0);
        dhit = 1;
        tick();
        chk("halt_ld_halt", {31'd0, halt}, 32'd1);
        chk("halt_ld_wdat", wb_wdat, 32'h1111);
        chk("halt_ld_wait_cnt", wait_cnt, 32'd2);

        // Reset asserted while a load is waiting.
        hard_reset();
        regWEN_in = 1; writeReg_in = 5'd4; aluOutport_in = 32'hABC;
        tick();
        dMemREN_in = 1; MemToReg_in = 1; dhit = 0;
        tick();
        chk("wait_pre_stall", {31'd0, mem_stall}, 32'd1);
        #1 nRST = 1'b0;
        #1;
        chk("rstw_dmemREN", {31'd0, dmemREN}, 32'd0);
        chk("rstw_stall", {31'd0, mem_stall}, 32'd0);
        chk("rstw_wb_wdat", wb_wdat, 32'd0);
        chk("rstw_wb_writeReg", {27'd0, wb_writeReg}, 32'd0);
        chk("rstw_wait_cnt", wait_cnt, 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        dhit = 1;
        #1;
        chk("rstw_rel_dmemREN", {31'd0, dmemREN}, 32'd1);
        chk("rstw_rel_stall", {31'd0, mem_stall}, 32'd0);
        tick();

        // Random traffic against the model, with periodic asynchronous resets.
        hard_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            if (i % 60 == 59) begin
                nRST = 1'b0;
                #1;
                chk("rnd_rst_dmemREN", {31'd0, dmemREN}, 32'd0);
                chk("rnd_rst_stall", {31'd0, mem_stall}, 32'd0);
                chk("rnd_rst_halt", {31'd0, halt}, 32'd0);
                @(negedge CLK);
                nRST = 1'b1;
                model_reset();
            end
            aluOutport_in = $urandom; rdat2_in = $urandom; pcplus4_in = $urandom;
            dmemload = $urandom; instr_in = $urandom; next_pc_in = $urandom;
            writeReg_in = 5'($urandom_range(0, 31));
            regWEN_in   = 1'($urandom_range(0, 1));
            MemToReg_in = 1'($urandom_range(0, 1));
            JType_in    = 1'($urandom_range(0, 1));
            dMemREN_in  = 1'($urandom_range(0, 1));
            dMemWEN_in  = 1'($urandom_range(0, 1));
            dhit        = 1'($urandom_range(0, 1));
            Halt_in     = ($urandom_range(0, 24) == 0);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
